uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
//
// PURPOSE
//  Byte FIFO sitting directly upstream of the UART transmitter. The CPU/bus side pushes bytes at
//  full clock rate. The read side presents bytes with a valid/ready handshake wired straight to the
//  transmitter (o_valid->i_valid, o_data->i_data, i_ready<-o_ready), so software never stalls per character.
//  Status (full/empty/level) is exported for a bus status register.
//
// PARAMETERS
//  DEPTH       16   number of entries; power of two, >= 2
//  DATA_WIDTH   8   bits per entry
//
// PORTS
//  i_clk        in   1                  system clock, all logic on rising edge
//  i_rst_n      in   1                  asynchronous active-low reset
//  i_wr_data    in   DATA_WIDTH         byte to enqueue
//  i_wr_en      in   1                  push request, single-cycle pulse or held
//  o_full       out  1                  no free entry
//  o_empty      out  1                  no stored entry
//  o_level      out  $clog2(DEPTH)+1    entries currently stored, 0..DEPTH
//  o_data       out  DATA_WIDTH         head entry (first-word-fall-through)
//  o_valid      out  1                  head entry valid (== !o_empty)
//  i_ready      in   1                  consumer accepts head this cycle
//  i_ovf_clr    in   1                  clears o_overflow (OVF feature only)
//  o_overflow   out  1                  sticky: push attempted while full
//
// BEHAVIOUR
//  - Storage: DEPTH x DATA_WIDTH register array. Write and read pointers are $clog2(DEPTH)+1 bits wide.
//    The MSB is a wrap bit. Empty when pointers are equal. Full when the low bits are equal and the MSBs differ.
//  - Reset (i_rst_n low, async): pointers=0, level=0, o_empty=1, o_full=0, o_valid=0, o_overflow=0.
//    o_data is don't-care while o_valid=0. The array is not cleared.
//  - Reset mid-operation: every queued byte is discarded immediately. A byte already handed to the
//    transmitter is its responsibility.
//  - Push: accepted when i_wr_en & !o_full. The byte is written at wr_ptr and wr_ptr increments on the same edge.
//    A push while full is dropped, and the array and pointers are unchanged.
//  - Pop: occurs when o_valid & i_ready. rd_ptr increments on the edge, and the next entry appears on o_data after that edge.
//  - FWFT latency: a byte pushed into an empty FIFO at edge N is on o_data with o_valid=1 after edge N.
//    There is no push-to-pop bypass in the same cycle.
//  - Simultaneous push+pop:
//    - Normal case: both happen and the level is unchanged.
//    - When full: only the pop happens, because full is sampled before the pop. The push is dropped.
//    - When empty: only the push happens.
//  - Pointers wrap modulo 2*DEPTH. The level is wr_ptr - rd_ptr in $clog2(DEPTH)+1-bit arithmetic, so it is
//    correct across wrap.
//  - All status outputs are registered or derived from registered pointers only. There is no combinational
//    path from i_wr_en or i_ready to any output.
//  - o_data must stay stable while o_valid=1 and i_ready=0. This is required because the transmitter may not
//    accept for a full character time.
//
// CONFIGURATION
//  UART_TX_FIFO_OVF_EN defined:
//   - o_overflow is set on the edge after any cycle with i_wr_en & o_full.
//   - It is cleared by i_ovf_clr.
//   - If set and clear occur in the same cycle, set wins.
//  UART_TX_FIFO_OVF_EN undefined:
//   - o_overflow is tied to 0 and i_ovf_clr is ignored. The ports remain, so top-level wiring is unchanged.
//
// TESTING
//  1. Reset, then push 0x41 with i_ready=0 -> after 1 edge: o_valid=1, o_data=0x41, level=1, empty=0.
//     Hold i_ready=0 for 1000 cycles -> o_data is still 0x41.
//  2. Push 16 bytes 0x00..0x0F with i_ready=0 -> full=1, level=16. Push 0xFF -> dropped.
//     Drain -> 0x00..0x0F in order, then empty=1.
//  3. With the FIFO full, assert push (0xAA) and pop in the same cycle -> level=15, head=0x01, 0xAA is not stored.
//     With level=5, push+pop -> level stays 5.
//  4. Run 40 push/pop pairs so the pointers wrap twice -> the data order is preserved and level never leaves 0..16.
//     Then connect the uart_tx model and send "OK" -> its line shows 0x4F then 0x4B.
//  5. With level=7, pulse i_rst_n low asynchronously between edges -> o_valid/level drop immediately to 0, empty=1.
//     After release, push 0x55 -> head=0x55.
//  6. With OVF_EN: push while full -> o_overflow=1 next edge. Assert overflow-push and i_ovf_clr together -> remains 1.
//     Assert i_ovf_clr alone -> 0. With the macro undefined -> o_overflow stays 0 throughout.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the UART transmitter, with registered status.
// Optional sticky overflow flag enabled by defining UART_TX_FIFO_OVF_EN.
module uart_tx_fifo #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic                    i_wr_en,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  input  logic                    i_ovf_clr,
  output logic                    o_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign push  = i_wr_en && !full;
  assign pop   = !empty && i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= i_wr_data;
  end

  assign o_full  = full;
  assign o_empty = empty;
  assign o_valid = !empty;
  assign o_level = wr_ptr - rd_ptr;
  assign o_data  = mem[rd_ptr[AW-1:0]];

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q;

  // Set has priority over clear so a concurrent overflow is never lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_q <= 1'b0;
    end else if (i_wr_en && full) begin
      ovf_q <= 1'b1;
    end else if (i_ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign o_overflow = ovf_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = i_ovf_clr;
  assign o_overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: directed scenarios plus random traffic against a queue model.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int DW    = 8;
`ifdef UART_TX_FIFO_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          full;
  logic          empty;
  logic [4:0]    level;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic          ovf_clr;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  byte unsigned q[$];
  bit ovf_m = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_data(wr_data), .i_wr_en(wr_en),
    .o_full(full), .o_empty(empty), .o_level(level), .o_data(data),
    .o_valid(valid), .i_ready(ready), .i_ovf_clr(ovf_clr), .o_overflow(overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: mid-cycle, compare DUT against the queue model, then apply this cycle's push/pop.
  always @(negedge clk) begin
    int n;
    bit m_full;
    if (!rst_n) begin
      q.delete();
      ovf_m = 1'b0;
      chk("rst_level", 32'(level), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_overflow", 32'(overflow), 0);
    end else begin
      n = q.size();
      m_full = (n == DEPTH);
      chk("level", 32'(level), 32'(n));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("full", 32'(full), 32'(m_full));
      chk("valid", 32'(valid), 32'(n != 0));
      chk("overflow", 32'(overflow), 32'(ovf_m));
      if (n != 0) chk("head_data", 32'(data), 32'(q[0]));
      if (OVF_ON) begin
        if (wr_en && m_full) ovf_m = 1'b1;
        else if (ovf_clr) ovf_m = 1'b0;
      end
      if (n != 0 && ready) void'(q.pop_front());
      if (wr_en && !m_full) q.push_back(wr_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] b);
    wr_en = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain();
    ready = 1'b1;
    for (int i = 0; i < 100 && !empty; i++) tick();
    ready = 1'b0;
    chk("drain_empty", 32'(empty), 1);
  endtask

  initial begin
    byte unsigned line[$];
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("init_level", 32'(level), 0);
    chk("init_empty", 32'(empty), 1);

    // 1: FWFT latency and hold stability
    push(8'h41);
    chk("t1_valid", 32'(valid), 1);
    chk("t1_data", 32'(data), 32'h41);
    chk("t1_level", 32'(level), 1);
    chk("t1_empty", 32'(empty), 0);
    repeat (1000) tick();
    chk("t1_hold", 32'(data), 32'h41);
    drain();

    // 2: fill, drop on full, drain in order
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("t2_full", 32'(full), 1);
    chk("t2_level", 32'(level), 16);
    push(8'hFF);
    chk("t2_drop_level", 32'(level), 16);
    chk("t2_head", 32'(data), 0);
    drain();

    // 3: push+pop while full, then at level 5
    for (int i = 0; i < 16; i++) push(8'(i));
    wr_en = 1'b1; wr_data = 8'hAA; ready = 1'b1;
    tick();
    wr_en = 1'b0; ready = 1'b0;
    chk("t3_full_level", 32'(level), 15);
    chk("t3_full_head", 32'(data), 32'h01);
    ready = 1'b1;
    repeat (10) tick();
    ready = 1'b0;
    chk("t3_level5", 32'(level), 5);
    wr_en = 1'b1; wr_data = 8'($urandom); ready = 1'b1;
    tick();
    wr_en = 1'b0; ready = 1'b0;
    chk("t3_pushpop_level", 32'(level), 5);
    drain();

    // 4: wrap with push/pop pairs, random traffic, then "OK" through a slow consumer
    for (int i = 0; i < 40; i++) begin
      push(8'(8'h20 + i));
      ready = 1'b1;
      tick();
      ready = 1'b0;
    end
    for (int i = 0; i < 400; i++) begin
      wr_en = 1'($urandom_range(0, 1));
      ready = 1'($urandom_range(0, 1));
      wr_data = 8'($urandom);
      ovf_clr = ($urandom_range(0, 7) == 0);
      tick();
      chk("t4_level_range", 32'(level <= 5'(DEPTH)), 1);
    end
    wr_en = 1'b0; ovf_clr = 1'b0;
    drain();
    push(8'h4F);
    push(8'h4B);
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 50 && !valid; t++) tick();
      ready = 1'b1;
      line.push_back(data);
      tick();
      ready = 1'b0;
      repeat (39) tick();
    end
    chk("t4_line_count", 32'(line.size()), 2);
    if (line.size() == 2) begin
      chk("t4_line_O", 32'(line[0]), 32'h4F);
      chk("t4_line_K", 32'(line[1]), 32'h4B);
    end

    // 5: asynchronous reset between edges
    for (int i = 0; i < 7; i++) push(8'($urandom));
    chk("t5_level7", 32'(level), 7);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(valid), 0);
    chk("t5_rst_level", 32'(level), 0);
    chk("t5_rst_empty", 32'(empty), 1);
    q.delete();
    ovf_m = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    push(8'h55);
    chk("t5_head", 32'(data), 32'h55);
    drain();

    // 6: overflow flag set/clear priority
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("t6_pre", 32'(overflow), 0);
    push(8'h77);
    chk("t6_set", 32'(overflow), 32'(OVF_ON));
    wr_en = 1'b1; ovf_clr = 1'b1;
    tick();
    wr_en = 1'b0; ovf_clr = 1'b0;
    chk("t6_set_wins", 32'(overflow), 32'(OVF_ON));
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t6_clear", 32'(overflow), 0);
    drain();

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
